// File: rtl/match_controller.sv
// -----------------------------------------------------------------------------
// match_controller
//
// Runs a multi-round robot match around the scoreboard block. While a round is
// in play it lets the sensor inputs through to the scoreboard. When the
// scoreboard raises map_change (rising edge = round over), it waits out a
// settle window. It then either ends the match or pulses map_rst to start the
// next round.
//
// Optional feature: define MATCH_TIMEOUT_EN to add a per-round PLAY timeout.
// A round that has no map_change edge within TIMEOUT_CYCLES PLAY cycles is
// closed as if the edge had arrived, and the sticky timeout_flag is set.
// Without the macro no timeout counter is built and timeout_flag is tied to 0.
//
// Ports
//   clk          in   1   system clock, rising edge
//   board_rst    in   1   asynchronous, active-high reset
//   start        in   1   begin match; only looked at in IDLE
//   map_change   in   1   scoreboard level; rising edge ends the round
//   score        in  16   [15:8] bot1 score, [7:0] bot2 score (unsigned)
//   sensor_en    out  1   1 = sensors routed to scoreboard (PLAY only)
//   map_rst      out  1   map reset pulse to scoreboard
//   round        out  4   current round number, 0 when idle
//   state        out  3   FSM state (debug): IDLE=0 PLAY=1 SETTLE=2 MAPRST=3 DONE=4
//   match_over   out  1   high in DONE
//   winner       out  2   00 none, 01 bot1, 10 bot2, 11 tie (valid with match_over)
//   timeout_flag out  1   sticky: some round was closed by timeout
// -----------------------------------------------------------------------------
module match_controller #(
  parameter int WIN_SCORE      = 5,
  parameter int MAX_ROUNDS     = 9,
  parameter int SETTLE_CYCLES  = 10,
  parameter int RST_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        board_rst,
  input  logic        start,
  input  logic        map_change,
  input  logic [15:0] score,
  output logic        sensor_en,
  output logic        map_rst,
  output logic [3:0]  round,
  output logic [2:0]  state,
  output logic        match_over,
  output logic [1:0]  winner,
  output logic        timeout_flag
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAY   = 3'd1,
    S_SETTLE = 3'd2,
    S_MAPRST = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // One down-counter serves both the settle window and the map_rst pulse.
  localparam int CNT_MAX = (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           cur, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       round_nxt;
  logic             sensor_en_nxt, map_rst_nxt, match_over_nxt;
  logic [1:0]       winner_nxt;
  logic             map_change_d;
  logic             rise;
  logic             timeout_hit;
  logic             end_match;
  logic [7:0]       bot1, bot2;

  assign bot1  = score[15:8];
  assign bot2  = score[7:0];
  assign rise  = map_change & ~map_change_d;
  assign state = cur;

  // Match is over once either bot reaches the winning score or the final
  // round has just been played.
  assign end_match = (bot1 >= 8'(WIN_SCORE)) || (bot2 >= 8'(WIN_SCORE)) ||
                     (round == 4'(MAX_ROUNDS));

`ifdef MATCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] play_cnt;

  // Held at zero outside PLAY, so every PLAY entry starts counting from 0.
  // The value in a PLAY cycle is the number of PLAY cycles already elapsed.
  always_ff @(posedge clk or posedge board_rst) begin
    if (board_rst)          play_cnt <= '0;
    else if (cur != S_PLAY) play_cnt <= '0;
    else                    play_cnt <= play_cnt + 1'b1;
  end

  // A real edge in the same cycle takes precedence over the timeout.
  assign timeout_hit = (cur == S_PLAY) && !rise && (play_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge board_rst) begin
    if (board_rst)        timeout_flag <= 1'b0;
    else if (timeout_hit) timeout_flag <= 1'b1;
  end
`else
  assign timeout_hit  = 1'b0;
  // Constant false; it also keeps TIMEOUT_CYCLES referenced in this build.
  assign timeout_flag = (TIMEOUT_CYCLES < 0);
`endif

  // State and all outputs are registered together.
  always_ff @(posedge clk or posedge board_rst) begin
    if (board_rst) begin
      cur          <= S_IDLE;
      cnt          <= '0;
      round        <= '0;
      sensor_en    <= 1'b0;
      map_rst      <= 1'b0;
      match_over   <= 1'b0;
      winner       <= 2'b00;
      map_change_d <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, so their order inside this block does not matter.
      cur          <= nxt;
      cnt          <= cnt_nxt;
      round        <= round_nxt;
      sensor_en    <= sensor_en_nxt;
      map_rst      <= map_rst_nxt;
      match_over   <= match_over_nxt;
      winner       <= winner_nxt;
      map_change_d <= map_change;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting every output of a combinational block first means no
    // path leaves a value unassigned, which would otherwise infer a latch.
    nxt       = cur;
    cnt_nxt   = cnt;
    round_nxt = round;
    unique case (cur)
      S_IDLE: begin
        if (start) begin
          nxt       = S_PLAY;
          round_nxt = 4'd1;
        end
      end
      S_PLAY: begin
        if (rise || timeout_hit) begin
          nxt     = S_SETTLE;
          cnt_nxt = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          if (end_match) begin
            nxt = S_DONE;
          end else begin
            nxt     = S_MAPRST;
            cnt_nxt = CNT_W'(RST_CYCLES - 1);
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_MAPRST: begin
        if (cnt == '0) begin
          nxt       = S_PLAY;
          round_nxt = round + 4'd1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_DONE:  nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end

  // Output logic: registered outputs follow the state being entered.
  always_comb begin
    sensor_en_nxt  = (nxt == S_PLAY);
    map_rst_nxt    = (nxt == S_MAPRST);
    match_over_nxt = (nxt == S_DONE);
    winner_nxt     = winner;
    // Winner is captured from the same score sample that ended the match.
    if (cur == S_SETTLE && nxt == S_DONE) begin
      if (bot1 > bot2)      winner_nxt = 2'b01;
      else if (bot2 > bot1) winner_nxt = 2'b10;
      else                  winner_nxt = 2'b11;
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// -----------------------------------------------------------------------------
// tb_match_controller
//
// Self-checking bench for match_controller. Each round-ending map_change edge
// pushes the expected outcome onto a scoreboard: either a map_rst pulse or
// entry into DONE, together with the cycle, round and winner expected. A
// negedge monitor pops that entry when the DUT produces the event and compares
// it. Compile with +define+MATCH_TIMEOUT_EN to exercise the timeout build.
// -----------------------------------------------------------------------------
module tb_match_controller;

  localparam int WIN_SCORE  = 5;
  localparam int MAX_ROUNDS = 9;
  localparam int SETTLE     = 10;
  localparam int RSTC       = 1;
  localparam int TIMEOUT    = 50;

  logic        clk = 1'b0;
  logic        board_rst;
  logic        start;
  logic        map_change;
  logic [15:0] score;
  logic        sensor_en;
  logic        map_rst;
  logic [3:0]  round;
  logic [2:0]  state;
  logic        match_over;
  logic [1:0]  winner;
  logic        timeout_flag;

  match_controller #(
    .WIN_SCORE      (WIN_SCORE),
    .MAX_ROUNDS     (MAX_ROUNDS),
    .SETTLE_CYCLES  (SETTLE),
    .RST_CYCLES     (RSTC),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .board_rst    (board_rst),
    .start        (start),
    .map_change   (map_change),
    .score        (score),
    .sensor_en    (sensor_en),
    .map_rst      (map_rst),
    .round        (round),
    .state        (state),
    .match_over   (match_over),
    .winner       (winner),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef enum int {EV_MAPRST = 1, EV_DONE = 2} ev_e;
  typedef struct {
    ev_e kind;
    int  cycle;
    int  rnd;
    int  win;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t tmp_e;

  int n_pass      = 0;
  int n_checks    = 0;
  int round_model = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Monitor: compare each map_rst pulse and DONE entry with the scoreboard.
  logic prev_map  = 1'b0;
  logic prev_over = 1'b0;
  int   width     = 0;

  always @(negedge clk) begin
    if (map_rst && !prev_map) begin
      check("sb_has_maprst", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("ev_kind_maprst", map_rst ? EV_MAPRST : EV_DONE, mon_e.kind);
        check("maprst_cycle", cyc, mon_e.cycle);
        check("maprst_round", round, mon_e.rnd);
      end
    end
    if (map_rst) width++;
    else begin
      if (prev_map && !board_rst) check("maprst_width", width, RSTC);
      width = 0;
    end
    if (match_over && !prev_over) begin
      check("sb_has_done", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("ev_kind_done", match_over ? EV_DONE : EV_MAPRST, mon_e.kind);
        check("done_cycle", cyc, mon_e.cycle);
        check("done_round", round, mon_e.rnd);
        check("done_winner", winner, mon_e.win);
      end
    end
    prev_map  = map_rst;
    prev_over = match_over;
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    board_rst = 1'b1;
    sb.delete();
    round_model = 0;
    wait_cycles(2);
    board_rst = 1'b0;
    wait_cycles(1);
  endtask

  task automatic start_match();
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
    round_model = 1;
    check("start_round", round, 1);
    check("start_state", state, 1);
    check("start_sensor", sensor_en, 1);
  endtask

  // Raise map_change for `hold` cycles with the given score and follow the
  // round to its end (back in PLAY, or DONE).
  task automatic end_round(input logic [15:0] sc, input int hold);
    exp_t       e;
    logic [7:0] b1, b2;
    logic       done_exp;
    int         n;
    b1       = sc[15:8];
    b2       = sc[7:0];
    done_exp = (b1 >= 8'(WIN_SCORE)) || (b2 >= 8'(WIN_SCORE)) || (round_model == MAX_ROUNDS);
    e.kind   = done_exp ? EV_DONE : EV_MAPRST;
    e.cycle  = cyc + 1 + SETTLE;
    e.rnd    = round_model;
    e.win    = (b1 > b2) ? 1 : (b2 > b1) ? 2 : 3;
    sb.push_back(e);
    score      = sc;
    map_change = 1'b1;
    wait_cycles(1);
    check("sensor_off_after_rise", sensor_en, 0);
    check("state_settle", state, 2);
    wait_cycles(hold - 1);
    map_change = 1'b0;
    n = 0;
    while (!(match_over || (state == 3'd1 && !map_rst)) && n < 100) begin
      wait_cycles(1);
      n++;
    end
    check("round_end_in_time", n < 100, 1);
    if (done_exp) begin
      check("state_done", state, 4);
      check("match_over", match_over, 1);
      check("sensor_done", sensor_en, 0);
    end else begin
      round_model++;
      check("round_incr", round, round_model);
      check("sensor_back_on", sensor_en, 1);
      check("state_play", state, 1);
    end
  endtask

  initial begin
    int t0;
    int n;
    board_rst  = 1'b1;
    start      = 1'b0;
    map_change = 1'b0;
    score      = 16'h0000;

    // Reset state
    do_reset();
    check("rst_state", state, 0);
    check("rst_round", round, 0);
    check("rst_sensor", sensor_en, 0);
    check("rst_maprst", map_rst, 0);
    check("rst_over", match_over, 0);
    check("rst_winner", winner, 0);
    check("rst_timeout", timeout_flag, 0);

    // Single round, next round starts after the map_rst pulse
    start_match();
    wait_cycles(3);
    check("sensor_in_play", sensor_en, 1);
    end_round(16'h0100, 1);

    // Bot1 reaches the winning score: DONE, no map_rst, start ignored
    wait_cycles(2);
    end_round(16'h0502, 2);
    check("winner_bot1", winner, 1);
    start = 1'b1;
    wait_cycles(2);
    start = 1'b0;
    check("done_ignores_start", state, 4);
    check("done_round_held", round, 2);

    // Start with map_change already rising: start wins, rise ignored.
    // Then nine tied rounds, map_change held 5 cycles each.
    do_reset();
    map_change = 1'b1;
    start      = 1'b1;
    wait_cycles(1);
    start       = 1'b0;
    round_model = 1;
    check("start_beats_rise", state, 1);
    wait_cycles(3);
    check("rise_ignored_idle", state, 1);
    map_change = 1'b0;
    wait_cycles(2);
    for (int r = 1; r <= MAX_ROUNDS; r++) begin
      end_round(16'h0404, 5);
      if (r < MAX_ROUNDS) wait_cycles(2);
    end
    check("final_round", round, MAX_ROUNDS);
    check("winner_tie", winner, 3);
    check("final_state", state, 4);

    // board_rst during SETTLE
    do_reset();
    start_match();
    wait_cycles(2);
    score      = 16'h0000;
    map_change = 1'b1;
    wait_cycles(3);
    check("pre_rst_settle", state, 2);
    board_rst = 1'b1;
    #1;
    check("rst_settle_state", state, 0);
    check("rst_settle_round", round, 0);
    check("rst_settle_sensor", sensor_en, 0);
    map_change = 1'b0;
    wait_cycles(1);
    board_rst   = 1'b0;
    round_model = 0;
    wait_cycles(1);
    start_match();

    // board_rst during the map_rst pulse
    wait_cycles(2);
    t0         = cyc;
    map_change = 1'b1;
    n          = 0;
    while (cyc < t0 + 1 + SETTLE && n < 100) begin
      wait_cycles(1);
      n++;
    end
    check("maprst_reached", n < 100, 1);
    check("maprst_before_reset", map_rst, 1);
    board_rst = 1'b1;
    #1;
    check("rst_drops_maprst", map_rst, 0);
    check("rst_maprst_state", state, 0);
    check("rst_no_round_incr", round, 0);
    map_change = 1'b0;
    wait_cycles(1);
    board_rst   = 1'b0;
    round_model = 0;
    wait_cycles(1);
    start_match();

    // PLAY with no map_change
    do_reset();
    score = 16'h0000;
    start_match();
    wait_cycles(TIMEOUT - 1);
    check("play_before_timeout", state, 1);
    wait_cycles(1);
`ifdef MATCH_TIMEOUT_EN
    check("timeout_state", state, 2);
    check("timeout_flag_set", timeout_flag, 1);
    tmp_e.kind  = EV_MAPRST;
    tmp_e.cycle = cyc + SETTLE;
    tmp_e.rnd   = round_model;
    tmp_e.win   = 0;
    sb.push_back(tmp_e);
    wait_cycles(SETTLE + RSTC + 2);
    check("timeout_next_round", round, 2);
    check("timeout_back_play", state, 1);
    check("timeout_flag_sticky", timeout_flag, 1);
`else
    check("no_timeout_state", state, 1);
    check("no_timeout_flag", timeout_flag, 0);
    wait_cycles(20);
    check("no_timeout_still_play", state, 1);
    check("no_timeout_flag_later", timeout_flag, 0);
`endif

    wait_cycles(2);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
